// File: rtl/aurora_rx_pkg.sv
// Shared types and constants for the Aurora 64b/66b receive path.
package aurora_rx_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} lock_state_t;

  localparam logic [1:0]  SYNC_DATA = 2'b01;
  localparam logic [1:0]  SYNC_CTRL = 2'b10;
  localparam int unsigned BLK_W     = 66;
  localparam int unsigned BUF_W     = 194;
  localparam int unsigned OFF_W     = 7;

  function automatic logic hdr_is_legal(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Block-lock state machine: qualifies the seeker offset against a run of legal
// headers, then watches for a run of illegal ones to drop lock.
module block_lock_fsm
  import aurora_rx_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hdr_legal_i,
  input  logic             beat_i,
  input  logic             is_synced_i,
  input  logic             offset_change_i,
  input  logic [OFF_W-1:0] offset_pos_i,
  output logic [OFF_W-1:0] off_o,
  output logic             emit_o,
  output logic             resync_o,
  output logic             locked_d_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  lock_state_t      state_q, state_d;
  logic [7:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [ERR_W-1:0] err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
      off_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    off_d    = off_q;
    err_d    = err_q;
    emit_o   = 1'b0;
    resync_o = 1'b0;
    if (!is_synced_i) begin
      state_d  = HUNT;
      resync_o = (state_q == LOCKED);
    end else if (state_q == HUNT || offset_change_i) begin
      resync_o = (state_q == LOCKED);
      off_d    = offset_pos_i;
      good_d   = '0;
      bad_d    = '0;
      state_d  = VERIFY;
    end else if (beat_i) begin
      if (state_q == VERIFY) begin
        if (hdr_legal_i) begin
          good_d = good_q + 8'd1;
          if (good_d == 8'(LOCK_CNT)) state_d = LOCKED;
        end else begin
          good_d = '0;
        end
      end else begin
        emit_o = 1'b1;
        if (hdr_legal_i) begin
          bad_d = '0;
        end else begin
          bad_d = bad_q + 4'd1;
          if (err_q != '1) err_d = err_q + 1'b1;
          if (bad_d == 4'(UNLOCK_CNT)) begin
            state_d  = HUNT;
            resync_o = 1'b1;
          end
        end
      end
    end
  end

  assign off_o      = off_q;
  assign locked_d_o = (state_d == LOCKED);
  assign err_cnt_o  = err_q;

endmodule

// File: rtl/aurora_block_lock.sv
// Extracts one 66-bit block per valid gearbox beat at the locked offset and
// registers the header/payload stream for the descrambler.
module aurora_block_lock
  import aurora_rx_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BUF_W-1:0] gbox_buffer,
  input  logic             buffer_dv,
  input  logic             is_synced,
  input  logic [OFF_W-1:0] offset_pos,
  output logic [1:0]       blk_hdr_o,
  output logic [63:0]      blk_data_o,
  output logic             blk_dv_o,
  output logic             hdr_err_o,
  output logic             locked_o,
  output logic             resync_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic [OFF_W-1:0] off_q;
  logic [BLK_W-1:0] blk;
  logic             legal, emit, resync, locked_d;

  // Extraction always uses the offset held before this cycle's update.
  assign blk   = gbox_buffer[off_q +: BLK_W];
  assign legal = hdr_is_legal(blk[65:64]);

  block_lock_fsm #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT),
    .ERR_W     (ERR_W)
  ) u_fsm (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .hdr_legal_i    (legal),
    .beat_i         (buffer_dv),
    .is_synced_i    (is_synced),
    .offset_change_i(offset_pos != off_q),
    .offset_pos_i   (offset_pos),
    .off_o          (off_q),
    .emit_o         (emit),
    .resync_o       (resync),
    .locked_d_o     (locked_d),
    .err_cnt_o      (err_cnt_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      blk_hdr_o  <= '0;
      blk_data_o <= '0;
      blk_dv_o   <= 1'b0;
      hdr_err_o  <= 1'b0;
      locked_o   <= 1'b0;
      resync_o   <= 1'b0;
    end else begin
      blk_dv_o  <= emit;
      hdr_err_o <= emit & ~legal;
      locked_o  <= locked_d;
      resync_o  <= resync;
      if (buffer_dv) begin
        blk_hdr_o  <= blk[65:64];
        blk_data_o <= blk[63:0];
      end
    end
  end

endmodule
